// File: rtl/parity_frame_tx.sv
// parity_frame_tx: accepts one W-bit word over valid/ready and shifts it out
// MSB-first, one bit per clock, followed by an odd/even parity slot.
// Optional macro PARITY_FRAME_START_BIT_EN inserts a START slot (so_bit=0)
// ahead of the data bits.
module parity_frame_tx #(
   parameter  int W  = 3,
   localparam int CW = $clog2(W)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_odd,
   output logic         in_ready,
   output logic         so_bit,
   output logic         so_valid,
   output logic         so_is_parity,
   output logic         frame_done,
   output logic         busy
);

`ifdef PARITY_FRAME_START_BIT_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_START  = 2'd3
   } state_t;
   localparam state_t FIRST_ST = S_START;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;
   localparam state_t FIRST_ST = S_DATA;
`endif

   state_t          state_q, state_d;
   logic [W-1:0]    shift_q, shift_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            par_q, par_d;
   logic            so_bit_q, so_bit_d;
   logic            so_valid_q, so_valid_d;
   logic            so_is_parity_q, so_is_parity_d;
   logic            frame_done_q, frame_done_d;
   logic            busy_q, busy_d;
   logic            accept;

   // Ready is decoded from state: IDLE, or PARITY for back-to-back framing.
   always_comb begin
      in_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
      accept   = in_valid && in_ready;
   end

   // Next-state and next-output computation; outputs describe the slot
   // produced by the current state and appear one clock later.
   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      cnt_d          = cnt_q;
      par_d          = par_q;
      so_bit_d       = 1'b0;
      so_valid_d     = 1'b0;
      so_is_parity_d = 1'b0;
      frame_done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d = in_data;
               par_d   = in_odd ? ~^in_data : ^in_data;
               cnt_d   = CW'(W - 1);
               state_d = FIRST_ST;
            end
         end
`ifdef PARITY_FRAME_START_BIT_EN
         S_START: begin
            so_valid_d = 1'b1;
            state_d    = S_DATA;
         end
`endif
         S_DATA: begin
            so_valid_d = 1'b1;
            so_bit_d   = shift_q[W-1];
            shift_d    = {shift_q[W-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = S_PARITY;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_PARITY: begin
            so_valid_d     = 1'b1;
            so_is_parity_d = 1'b1;
            frame_done_d   = 1'b1;
            so_bit_d       = par_q;
            if (accept) begin
               shift_d = in_data;
               par_d   = in_odd ? ~^in_data : ^in_data;
               cnt_d   = CW'(W - 1);
               state_d = FIRST_ST;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // All state and registered outputs; async active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         shift_q        <= '0;
         cnt_q          <= '0;
         par_q          <= 1'b0;
         so_bit_q       <= 1'b0;
         so_valid_q     <= 1'b0;
         so_is_parity_q <= 1'b0;
         frame_done_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         cnt_q          <= cnt_d;
         par_q          <= par_d;
         so_bit_q       <= so_bit_d;
         so_valid_q     <= so_valid_d;
         so_is_parity_q <= so_is_parity_d;
         frame_done_q   <= frame_done_d;
         busy_q         <= busy_d;
      end
   end

   assign so_bit       = so_bit_q;
   assign so_valid     = so_valid_q;
   assign so_is_parity = so_is_parity_q;
   assign frame_done   = frame_done_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx (W=3); honours PARITY_FRAME_START_BIT_EN.
module tb_parity_frame_tx;
   localparam int W = 3;
`ifdef PARITY_FRAME_START_BIT_EN
   localparam int S = 1;
`else
   localparam int S = 0;
`endif
   localparam int L = W + 1 + S;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_odd = 1'b1;
   logic         in_ready, so_bit, so_valid, so_is_parity, frame_done, busy;

   int total = 0;
   int bad   = 0;

   parity_frame_tx #(.W(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_odd       (in_odd),
      .in_ready     (in_ready),
      .so_bit       (so_bit),
      .so_valid     (so_valid),
      .so_is_parity (so_is_parity),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // Expected slot k of a frame whose data+parity pattern is bits (MSB first).
   function automatic logic slot_bit(input logic [W:0] bits, input int k);
      if (k < S) return 1'b0;
      return bits[W - (k - S)];
   endfunction

   // One isolated frame: accept, then check every slot and the return to idle.
   task automatic send_frame(input string name, input logic [W-1:0] word,
                             input logic odd, input logic [W:0] bits);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_rdy"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = word;
      in_odd   = odd;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~word;
      in_odd   = ~odd;
      chk({name, "_acc_valid"}, so_valid, 1'b0);
      chk({name, "_acc_busy"}, busy, 1'b1);
      chk({name, "_acc_rdy"}, in_ready, 1'b0);
      for (int k = 0; k < L; k++) begin
         @(negedge clk);
         chk($sformatf("%s_bit%0d", name, k), so_bit, slot_bit(bits, k));
         chk($sformatf("%s_val%0d", name, k), so_valid, 1'b1);
         chk($sformatf("%s_par%0d", name, k), so_is_parity, k == L - 1);
         chk($sformatf("%s_done%0d", name, k), frame_done, k == L - 1);
         chk($sformatf("%s_rdy%0d", name, k), in_ready, k >= L - 2);
         chk($sformatf("%s_busy%0d", name, k), busy, k < L - 1);
      end
      @(negedge clk);
      chk({name, "_end_valid"}, so_valid, 1'b0);
      chk({name, "_end_done"}, frame_done, 1'b0);
   endtask

   initial begin
      logic [W:0] f1;
      logic [W:0] f2;

      // Reset held low for two cycles
      @(negedge clk);
      @(negedge clk);
      chk("rst_bit", so_bit, 1'b0);
      chk("rst_valid", so_valid, 1'b0);
      chk("rst_par", so_is_parity, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_rdy", in_ready, 1'b1);
      chk("rel_busy", busy, 1'b0);
      chk("rel_valid", so_valid, 1'b0);

      // Odd parity, isolated words
      send_frame("odd000", 3'b000, 1'b1, 4'b0001);
      send_frame("odd110", 3'b110, 1'b1, 4'b1101);
      send_frame("odd101", 3'b101, 1'b1, 4'b1011);
      send_frame("odd011", 3'b011, 1'b1, 4'b0111);

      // Even parity
      send_frame("even110", 3'b110, 1'b0, 4'b1100);
      send_frame("even111", 3'b111, 1'b0, 4'b1111);

      // Back-to-back: 111 held valid, then 010 accepted in the parity slot
      f1 = 4'b1110;
      f2 = 4'b0100;
      in_valid = 1'b1;
      in_data  = 3'b111;
      in_odd   = 1'b1;
      @(negedge clk);
      chk("b2b_acc_valid", so_valid, 1'b0);
      for (int k = 0; k < 2 * L; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_bit%0d", k), so_bit,
             (k < L) ? slot_bit(f1, k) : slot_bit(f2, k - L));
         chk($sformatf("b2b_val%0d", k), so_valid, 1'b1);
         chk($sformatf("b2b_par%0d", k), so_is_parity,
             (k == L - 1) || (k == 2 * L - 1));
         chk($sformatf("b2b_rdy%0d", k), in_ready,
             (k == L - 2) || (k >= 2 * L - 2));
         if (k == L - 2) in_data = 3'b010;
         if (k == L - 1) in_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_end_valid", so_valid, 1'b0);
      chk("b2b_end_busy", busy, 1'b0);

      // Reset during the second data bit of 101
      in_valid = 1'b1;
      in_data  = 3'b101;
      in_odd   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < S + 2; k++) @(negedge clk);
      chk("mid_valid_pre", so_valid, 1'b1);
      chk("mid_busy_pre", busy, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("mid_bit", so_bit, 1'b0);
      chk("mid_valid", so_valid, 1'b0);
      chk("mid_par", so_is_parity, 1'b0);
      chk("mid_done", frame_done, 1'b0);
      chk("mid_busy", busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rel_rdy", in_ready, 1'b1);
      chk("mid_rel_valid", so_valid, 1'b0);
      send_frame("post011", 3'b011, 1'b1, 4'b0111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
